// File: rtl/ppu_bg_shifter_if.sv
// Fetch-side strobes, scroll/clip controls and pixel outputs of the background shifter.
// master drives the fetch/control side; slave is the shifter itself.
interface ppu_bg_shifter_if;
    logic       dot_tick;
    logic       line_start;
    logic       at_wr;
    logic [1:0] at_data;
    logic       pt_lsb_wr;
    logic       pt_msb_wr;
    logic [7:0] pt_data;
    logic       tile_reload;
    logic [2:0] fine_x;
    logic [8:0] dot_x;
    logic       bg_enable;
    logic       bg_left_en;
    logic [3:0] bg_pixel;
    logic       bg_opaque;
    logic       bg_valid;

    modport master (
        output dot_tick, line_start, at_wr, at_data, pt_lsb_wr, pt_msb_wr, pt_data,
               tile_reload, fine_x, dot_x, bg_enable, bg_left_en,
        input  bg_pixel, bg_opaque, bg_valid
    );

    modport slave (
        input  dot_tick, line_start, at_wr, at_data, pt_lsb_wr, pt_msb_wr, pt_data,
               tile_reload, fine_x, dot_x, bg_enable, bg_left_en,
        output bg_pixel, bg_opaque, bg_valid
    );
endinterface

// File: rtl/ppu_bg_shifter.sv
// PPU background shifter: staging latches, per-tile reload, per-dot shift, palette index out.
// Define PPU_BG_FINE_X_EN to let fine_x select the tap; otherwise taps are fixed at the MSBs.
module ppu_bg_shifter #(
    parameter int LEFT_CLIP_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    ppu_bg_shifter_if.slave   bus
);
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_READY} state_t;

    localparam logic [9:0] CLIP_LIMIT = 10'(LEFT_CLIP_WIDTH);

    state_t     r_state;
    logic       r_valid;
    logic [1:0] r_at_stage;
    logic [7:0] r_lsb_stage;
    logic [7:0] r_msb_stage;
    logic [3:0] r_pixel;
    logic       r_opaque;

    logic       w_shift;
    logic       w_blank;
    logic [7:0] w_stage [2];
    logic [1:0] w_pat_bit;
    logic [1:0] w_att_bit;

    assign w_shift    = bus.dot_tick & bus.bg_enable;
    assign w_stage[0] = r_lsb_stage;
    assign w_stage[1] = r_msb_stage;

`ifdef PPU_BG_FINE_X_EN
    logic [3:0] w_pat_idx;
    logic [2:0] w_att_idx;
    assign w_pat_idx = 4'd15 - {1'b0, bus.fine_x};
    assign w_att_idx = 3'd7 - bus.fine_x;
`else
    logic w_unused_fine_x;
    assign w_unused_fine_x = ^bus.fine_x;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_at_stage  <= '0;
            r_lsb_stage <= '0;
            r_msb_stage <= '0;
        end else begin
            if (bus.at_wr)     r_at_stage  <= bus.at_data;
            if (bus.pt_lsb_wr) r_lsb_stage <= bus.pt_data;
            if (bus.pt_msb_wr) r_msb_stage <= bus.pt_data;
        end
    end

    // Plane 0 carries pattern LSB / attribute bit 0, plane 1 pattern MSB / attribute bit 1.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_plane
            logic [15:0] r_pat;
            logic [7:0]  r_att;
            logic        r_att_latch;
            logic [15:0] w_pat_shifted;

            assign w_pat_shifted = w_shift ? {r_pat[14:0], 1'b0} : r_pat;

            // A reload in a shift cycle overwrites only the freshly vacated low byte.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_pat       <= '0;
                    r_att       <= '0;
                    r_att_latch <= 1'b0;
                end else begin
                    if (w_shift) r_att <= {r_att[6:0], r_att_latch};
                    if (bus.tile_reload) begin
                        r_pat       <= {w_pat_shifted[15:8], w_stage[gi]};
                        r_att_latch <= r_at_stage[gi];
                    end else begin
                        r_pat <= w_pat_shifted;
                    end
                end
            end

`ifdef PPU_BG_FINE_X_EN
            assign w_pat_bit[gi] = r_pat[w_pat_idx];
            assign w_att_bit[gi] = r_att[w_att_idx];
`else
            assign w_pat_bit[gi] = r_pat[15];
            assign w_att_bit[gi] = r_att[7];
`endif
        end
    endgenerate

    assign w_blank = !bus.bg_enable || !r_valid ||
                     (!bus.bg_left_en && ({1'b0, bus.dot_x} < CLIP_LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pixel  <= '0;
            r_opaque <= 1'b0;
        end else if (bus.dot_tick) begin
            if (w_blank) begin
                r_pixel  <= '0;
                r_opaque <= 1'b0;
            end else begin
                r_pixel  <= {w_att_bit, w_pat_bit};
                r_opaque <= |w_pat_bit;
            end
        end
    end

    // Two reloads are needed before the high bytes hold a real tile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_valid <= 1'b0;
        end else if (bus.line_start) begin
            r_state <= ST_EMPTY;
            r_valid <= 1'b0;
        end else if (bus.tile_reload) begin
            case (r_state)
                ST_EMPTY: begin
                    r_state <= ST_ONE;
                    r_valid <= 1'b0;
                end
                ST_ONE, ST_READY: begin
                    r_state <= ST_READY;
                    r_valid <= 1'b1;
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bg_pixel  = r_pixel;
    assign bus.bg_opaque = r_opaque;
    assign bus.bg_valid  = r_valid;
endmodule
